// File: rtl/mem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter_if
// Brief    : Fetch, data and memory-port handshake bundle for mem_port_arbiter.
// Revision : 1.0
// ============================================================================
interface mem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic                  if_req;
    logic [ADDR_W-1:0]     if_addr;
    logic                  if_gnt;
    logic                  if_valid;
    logic [DATA_W-1:0]     if_rdata;

    logic                  d_req;
    logic                  d_we;
    logic [ADDR_W-1:0]     d_addr;
    logic [DATA_W-1:0]     d_wdata;
    logic [DATA_W/8-1:0]   d_wmask;
    logic                  d_gnt;
    logic                  d_valid;
    logic [DATA_W-1:0]     d_rdata;

    logic                  mem_req;
    logic                  mem_we;
    logic [ADDR_W-1:0]     mem_addr;
    logic [DATA_W-1:0]     mem_wdata;
    logic [DATA_W/8-1:0]   mem_wmask;
    logic                  mem_ack;
    logic [DATA_W-1:0]     mem_rdata;

    // The arbiter itself
    modport slave (
        input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wmask, mem_ack, mem_rdata,
        output if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
    );

    // Requesters plus memory, seen from outside the arbiter
    modport master (
        output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_wmask, mem_ack, mem_rdata,
        input  if_gnt, if_valid, if_rdata, d_gnt, d_valid, d_rdata,
               mem_req, mem_we, mem_addr, mem_wdata, mem_wmask
    );
endinterface
`default_nettype wire

// File: rtl/mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_port_arbiter
// Brief    : Shares one memory port between instruction fetch and load/store.
//            Define MEM_ARB_RR_EN for round-robin ties instead of data priority.
// Revision : 1.0
// ============================================================================
module mem_port_arbiter #(
    parameter int ADDR_W       = 32,
    parameter int DATA_W       = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    mem_port_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY_IF = 2'd1,
        BUSY_D  = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [ADDR_W-1:0]     addr_q, addr_d;
    logic                  we_q, we_d;
    logic [DATA_W-1:0]     wdata_q, wdata_d;
    logic [DATA_W/8-1:0]   wmask_q, wmask_d;
    logic [DATA_W-1:0]     if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]     d_rdata_q, d_rdata_d;
    logic                  if_valid_q, if_valid_d;
    logic                  d_valid_q, d_valid_d;
    logic                  w_gnt_if, w_gnt_d, w_tie_if;

`ifdef MEM_ARB_RR_EN
    logic last_if_q, last_if_d;

    always_comb w_tie_if = !last_if_q;

    always_comb begin
        last_if_d = last_if_q;
        if (w_gnt_if)
            last_if_d = 1'b1;
        else if (w_gnt_d)
            last_if_d = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) last_if_q <= 1'b0;
        else        last_if_q <= last_if_d;
    end
`else
    localparam int C_CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
    localparam logic [C_CNT_W-1:0] C_LIMIT = C_CNT_W'(STARVE_LIMIT);

    logic [C_CNT_W-1:0] starve_q, starve_d;

    always_comb w_tie_if = (STARVE_LIMIT != 0) && (starve_q == C_LIMIT);

    // Counts data wins taken while a fetch was waiting; saturates at the limit
    always_comb begin
        starve_d = starve_q;
        if (w_gnt_if)
            starve_d = '0;
        else if (w_gnt_d && bus.if_req && (starve_q != C_LIMIT))
            starve_d = starve_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) starve_q <= '0;
        else        starve_q <= starve_d;
    end
`endif

    always_comb begin
        w_gnt_if = 1'b0;
        w_gnt_d  = 1'b0;
        if (state_q == IDLE) begin
            if (bus.if_req && bus.d_req) begin
                w_gnt_if = w_tie_if;
                w_gnt_d  = !w_tie_if;
            end else begin
                w_gnt_if = bus.if_req;
                w_gnt_d  = bus.d_req;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        wmask_d    = wmask_q;
        if_rdata_d = if_rdata_q;
        d_rdata_d  = d_rdata_q;
        if_valid_d = 1'b0;
        d_valid_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_gnt_if) begin
                    state_d = BUSY_IF;
                    addr_d  = bus.if_addr;
                    we_d    = 1'b0;
                    wdata_d = '0;
                    wmask_d = '0;
                end else if (w_gnt_d) begin
                    state_d = BUSY_D;
                    addr_d  = bus.d_addr;
                    we_d    = bus.d_we;
                    wdata_d = bus.d_wdata;
                    wmask_d = bus.d_wmask;
                end
            end
            BUSY_IF: begin
                if (bus.mem_ack) begin
                    if_rdata_d = bus.mem_rdata;
                    if_valid_d = 1'b1;
                    state_d    = IDLE;
                end
            end
            BUSY_D: begin
                if (bus.mem_ack) begin
                    d_rdata_d = we_q ? '0 : bus.mem_rdata;
                    d_valid_d = 1'b1;
                    state_d   = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            wmask_q    <= '0;
            if_rdata_q <= '0;
            d_rdata_q  <= '0;
            if_valid_q <= 1'b0;
            d_valid_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            wmask_q    <= wmask_d;
            if_rdata_q <= if_rdata_d;
            d_rdata_q  <= d_rdata_d;
            if_valid_q <= if_valid_d;
            d_valid_q  <= d_valid_d;
        end
    end

    assign bus.if_gnt    = w_gnt_if;
    assign bus.d_gnt     = w_gnt_d;
    assign bus.if_valid  = if_valid_q;
    assign bus.d_valid   = d_valid_q;
    assign bus.if_rdata  = if_rdata_q;
    assign bus.d_rdata   = d_rdata_q;
    assign bus.mem_req   = (state_q != IDLE);
    assign bus.mem_we    = we_q && (state_q != IDLE);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = wdata_q;
    assign bus.mem_wmask = wmask_q;
endmodule
`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_port_arbiter
// Brief    : Directed and randomized self-checking bench for mem_port_arbiter.
// Revision : 1.0
// ============================================================================
module tb_mem_port_arbiter;
    localparam int ADDR_W       = 32;
    localparam int DATA_W       = 32;
    localparam int STARVE_LIMIT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    mem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    mem_port_arbiter #(
        .ADDR_W      (ADDR_W),
        .DATA_W      (DATA_W),
        .STARVE_LIMIT(STARVE_LIMIT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Transaction-level reference state
    bit          m_busy, m_is_if, m_we;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wmask;
    int          m_wait;
    bit          m_exp_ifv, m_exp_dv;
    logic [31:0] m_if_rdata, m_d_rdata;
    int          m_d_while_if;
    bit          m_last_if;

    int p_if, p_d, p_drop, p_idle_ack, lat_max;
    bit prev_gnt_if, prev_gnt_d;
    int g_log[$];
    int both_seen;

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_is_if = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_wmask = '0;
        m_wait = 0; m_exp_ifv = 0; m_exp_dv = 0; m_if_rdata = '0; m_d_rdata = '0;
        m_d_while_if = 0; m_last_if = 0;
        prev_gnt_if = 0; prev_gnt_d = 0;
    endtask

    task automatic chk_all_zero(input string pfx);
        chk1 ({pfx, "_if_gnt"},   bus.if_gnt,   1'b0);
        chk1 ({pfx, "_d_gnt"},    bus.d_gnt,    1'b0);
        chk1 ({pfx, "_if_valid"}, bus.if_valid, 1'b0);
        chk1 ({pfx, "_d_valid"},  bus.d_valid,  1'b0);
        chk32({pfx, "_if_rdata"}, bus.if_rdata, 32'h0);
        chk32({pfx, "_d_rdata"},  bus.d_rdata,  32'h0);
        chk1 ({pfx, "_mem_req"},  bus.mem_req,  1'b0);
        chk1 ({pfx, "_mem_we"},   bus.mem_we,   1'b0);
        chk32({pfx, "_mem_addr"}, bus.mem_addr, 32'h0);
        chk32({pfx, "_mem_wdata"}, bus.mem_wdata, 32'h0);
        chk32({pfx, "_mem_wmask"}, 32'(bus.mem_wmask), 32'h0);
    endtask

    task automatic do_reset();
        bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0;
        bus.d_wdata = '0; bus.d_wmask = '0; bus.mem_ack = 0; bus.mem_rdata = '0;
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk1("rst_async_mem_req", bus.mem_req, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("rst");
        rst_n = 1'b1;
        model_reset();
    endtask

    // One request, fixed memory latency (cycles of mem_req before mem_ack)
    task automatic directed_txn(input bit is_if, input logic [31:0] addr, input bit we,
                                input logic [31:0] wdata, input logic [3:0] wmask,
                                input logic [31:0] rdata, input int lat);
        if (is_if) begin
            bus.if_req = 1; bus.if_addr = addr;
        end else begin
            bus.d_req = 1; bus.d_we = we; bus.d_addr = addr; bus.d_wdata = wdata; bus.d_wmask = wmask;
        end
        #1;
        chk1("dir_if_gnt", bus.if_gnt, is_if);
        chk1("dir_d_gnt",  bus.d_gnt,  !is_if);
        @(posedge clk); #1;
        bus.if_req = 0; bus.d_req = 0;
        for (int i = 0; i <= lat; i++) begin
            chk1 ("dir_mem_req",  bus.mem_req,  1'b1);
            chk32("dir_mem_addr", bus.mem_addr, addr);
            chk1 ("dir_mem_we",   bus.mem_we,   we);
            if (we) begin
                chk32("dir_mem_wdata", bus.mem_wdata, wdata);
                chk32("dir_mem_wmask", 32'(bus.mem_wmask), 32'(wmask));
            end
            chk1("dir_busy_if_valid", bus.if_valid, 1'b0);
            chk1("dir_busy_d_valid",  bus.d_valid,  1'b0);
            if (i == lat) begin
                bus.mem_ack = 1; bus.mem_rdata = rdata;
            end
            @(posedge clk); #1;
        end
        bus.mem_ack = 0; bus.mem_rdata = $urandom;
        if (is_if) m_if_rdata = rdata;
        else       m_d_rdata  = we ? 32'h0 : rdata;
        chk1 ("dir_if_valid", bus.if_valid, is_if);
        chk1 ("dir_d_valid",  bus.d_valid,  !is_if);
        chk32("dir_if_rdata", bus.if_rdata, m_if_rdata);
        chk32("dir_d_rdata",  bus.d_rdata,  m_d_rdata);
        chk1 ("dir_done_mem_req", bus.mem_req, 1'b0);
        @(posedge clk); #1;
        chk1 ("dir_pulse_if_valid", bus.if_valid, 1'b0);
        chk1 ("dir_pulse_d_valid",  bus.d_valid,  1'b0);
        chk32("dir_hold_if_rdata",  bus.if_rdata, m_if_rdata);
        chk32("dir_hold_d_rdata",   bus.d_rdata,  m_d_rdata);
    endtask

    // One clock of random traffic checked against the reference model
    task automatic step();
        bit gi, gd;
        if (prev_gnt_if || !bus.if_req) begin
            if ($urandom_range(99) < p_if) begin bus.if_req = 1; bus.if_addr = $urandom; end
            else bus.if_req = 0;
        end else if ($urandom_range(99) < p_drop) bus.if_req = 0;
        if (prev_gnt_d || !bus.d_req) begin
            if ($urandom_range(99) < p_d) begin
                bus.d_req = 1; bus.d_we = 1'($urandom_range(1)); bus.d_addr = $urandom;
                bus.d_wdata = $urandom; bus.d_wmask = 4'($urandom_range(15));
            end else bus.d_req = 0;
        end else if ($urandom_range(99) < p_drop) bus.d_req = 0;
        if (m_busy) begin
            if (m_wait == 0) begin bus.mem_ack = 1; bus.mem_rdata = $urandom; end
            else begin bus.mem_ack = 0; m_wait--; end
        end else begin
            bus.mem_ack = ($urandom_range(99) < p_idle_ack);
            bus.mem_rdata = $urandom;
        end
        #1;
        gi = 0; gd = 0;
        if (!m_busy) begin
            if (bus.if_req && bus.d_req) begin
`ifdef MEM_ARB_RR_EN
                gi = !m_last_if;
`else
                gi = (STARVE_LIMIT != 0) && (m_d_while_if >= STARVE_LIMIT);
`endif
                gd = !gi;
            end else begin
                gi = bus.if_req; gd = bus.d_req;
            end
        end
        chk1("rnd_if_gnt",  bus.if_gnt,  gi);
        chk1("rnd_d_gnt",   bus.d_gnt,   gd);
        chk1("rnd_mem_req", bus.mem_req, m_busy);
        if (m_busy) begin
            chk32("rnd_mem_addr", bus.mem_addr, m_addr);
            chk1 ("rnd_mem_we",   bus.mem_we,   m_we);
            if (m_we) begin
                chk32("rnd_mem_wdata", bus.mem_wdata, m_wdata);
                chk32("rnd_mem_wmask", 32'(bus.mem_wmask), 32'(m_wmask));
            end
        end
        chk1 ("rnd_if_valid", bus.if_valid, m_exp_ifv);
        chk1 ("rnd_d_valid",  bus.d_valid,  m_exp_dv);
        chk32("rnd_if_rdata", bus.if_rdata, m_if_rdata);
        chk32("rnd_d_rdata",  bus.d_rdata,  m_d_rdata);
        if (bus.if_valid && bus.if_gnt) both_seen++;
        if (bus.if_gnt) g_log.push_back(1);
        else if (bus.d_gnt) g_log.push_back(0);

        m_exp_ifv = 0; m_exp_dv = 0;
        if (m_busy) begin
            if (bus.mem_ack) begin
                if (m_is_if) begin m_exp_ifv = 1; m_if_rdata = bus.mem_rdata; end
                else begin m_exp_dv = 1; m_d_rdata = m_we ? 32'h0 : bus.mem_rdata; end
                m_busy = 0;
            end
        end else if (gi || gd) begin
            m_busy  = 1;
            m_is_if = gi;
            m_addr  = gi ? bus.if_addr : bus.d_addr;
            m_we    = gi ? 1'b0 : bus.d_we;
            m_wdata = bus.d_wdata;
            m_wmask = bus.d_wmask;
            m_wait  = int'($urandom_range(lat_max, 0));
            if (gi) begin m_d_while_if = 0; m_last_if = 1; end
            else begin
                if (bus.if_req) m_d_while_if++;
                m_last_if = 0;
            end
        end
        prev_gnt_if = gi; prev_gnt_d = gd;
        @(posedge clk); #1;
    endtask

    initial begin
        int exp_order [10];
`ifdef MEM_ARB_RR_EN
        exp_order = '{1, 0, 1, 0, 1, 0, 1, 0, 1, 0};
`else
        exp_order = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
`endif
        model_reset();
        do_reset();

        directed_txn(1, 32'h100, 0, 32'h0, 4'h0, 32'hDEADBEEF, 3);
        directed_txn(0, 32'h200, 1, 32'h12345678, 4'b0011, 32'h55AA55AA, 2);
        directed_txn(0, 32'h204, 0, 32'h0, 4'h0, 32'hA5C3_0F1E, 0);

        // Both requesters held continuously, zero-wait memory
        do_reset();
        p_if = 100; p_d = 100; p_drop = 0; p_idle_ack = 0; lat_max = 0;
        g_log.delete();
        repeat (24) step();
        chk1("order_len", g_log.size() >= 10, 1'b1);
        for (int i = 0; i < 10 && i < g_log.size(); i++)
            chk32($sformatf("order_%0d", i), 32'(g_log[i]), 32'(exp_order[i]));

        // Fetch-only back-to-back with zero-wait memory
        do_reset();
        p_if = 100; p_d = 0; both_seen = 0;
        repeat (12) step();
        chk1("b2b_valid_with_gnt", both_seen >= 4, 1'b1);

        // Random mix including drops, idle acks and variable latency
        do_reset();
        p_if = 35; p_d = 35; p_drop = 10; p_idle_ack = 30; lat_max = 4;
        repeat (1500) step();

        // Reset while a store is in flight
        do_reset();
        bus.d_req = 1; bus.d_we = 1; bus.d_addr = 32'h400; bus.d_wdata = 32'hFEEDFACE; bus.d_wmask = 4'hF;
        #1;
        chk1("mid_d_gnt", bus.d_gnt, 1'b1);
        @(posedge clk); #1;
        bus.d_req = 0;
        chk1("mid_busy_mem_req", bus.mem_req, 1'b1);
        @(posedge clk); #2;
        rst_n = 1'b0;
        #1;
        chk1("mid_rst_mem_req", bus.mem_req, 1'b0);
        chk1("mid_rst_d_valid", bus.d_valid, 1'b0);
        @(posedge clk); #1;
        chk1("mid_rst_hold_mem_req", bus.mem_req, 1'b0);
        rst_n = 1'b1;
        model_reset();
        @(posedge clk); #1;
        chk1("mid_post_d_valid", bus.d_valid, 1'b0);
        chk1("mid_post_mem_req", bus.mem_req, 1'b0);
        directed_txn(1, 32'h300, 0, 32'h0, 4'h0, 32'hCAFEF00D, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single unified memory port between the instruction-fetch path (MAR/MDR fetch sequence) and the load/store data path.
- Each requester uses a req/gnt/valid handshake. The arbiter registers the winning request, drives the memory port, holds the request until the memory acknowledges, then returns the read data to the winner.
- Sits between the control/datapath and the memory model.

Parameters:
- ADDR_W, 32, address width of all address ports
- DATA_W, 32, data width of all data ports
- STARVE_LIMIT, 4, consecutive data grants allowed while a fetch is pending before fetch is forced; 0 = pure data priority, no forcing

Ports:
- clk  input  1  system clock, rising edge
- rst_n  input  1  asynchronous active-low reset
- if_req  input  1  fetch request; held until if_gnt
- if_addr  input  ADDR_W  fetch address; sampled at grant
- if_gnt  output  1  fetch request accepted (1-cycle pulse)
- if_valid  output  1  fetch data valid (1-cycle pulse)
- if_rdata  output  DATA_W  fetch read data
- d_req  input  1  data request; held until d_gnt
- d_we  input  1  1 = store, 0 = load
- d_addr  input  ADDR_W  data address
- d_wdata  input  DATA_W  store data
- d_wmask  input  DATA_W/8  store byte enables
- d_gnt  output  1  data request accepted (1-cycle pulse)
- d_valid  output  1  load data valid / store complete (1-cycle pulse)
- d_rdata  output  DATA_W  load data; 0 for stores
- mem_req  output  1  memory request, held until mem_ack
- mem_we  output  1  memory write enable
- mem_addr  output  ADDR_W  memory address
- mem_wdata  output  DATA_W  memory write data
- mem_wmask  output  DATA_W/8  memory byte enables
- mem_ack  input  1  memory done; mem_rdata valid this cycle
- mem_rdata  input  DATA_W  memory read data

Behaviour:
- One clock; asynchronous active-low reset on rst_n.
- Reset values: all outputs 0; state IDLE; starve counter 0; last-grant flop = data.
- States: IDLE, BUSY_IF, BUSY_D.
- IDLE:
  - if_gnt/d_gnt are combinational in IDLE.
  - The winner's fields (addr, we, wdata, wmask) are registered at the grant edge.
  - Next state is BUSY_IF or BUSY_D.
  - No request: stay IDLE, all grant outputs 0.
- Arbitration (default build):
  - Data wins ties unless starve counter == STARVE_LIMIT and STARVE_LIMIT != 0; then fetch wins.
  - Counter increments on each d_gnt issued while if_req=1, saturating at STARVE_LIMIT.
  - Counter clears on if_gnt.
- BUSY_x:
  - mem_req=1 and mem_* driven from the registered fields; stable until mem_ack.
  - On mem_ack: capture mem_rdata (stores capture 0) into x_rdata, pulse x_valid next cycle, go to IDLE.
- Latency: grant at cycle N, mem_req at N+1, valid at the cycle after mem_ack. Zero-wait memory (mem_ack at N+1) gives valid at N+2.
- Only one transaction is outstanding at a time.
- A requester's valid pulse and a new grant can coincide: the grant comes from IDLE in the same cycle as the valid pulse from the completed transaction.
- x_rdata holds its value until the next completion for that requester.
- Requests are ignored in BUSY states. A requester dropping req before its grant is legal and is simply not granted.
- mem_ack in IDLE is ignored.
- rst_n low mid-transaction: immediate return to IDLE, mem_req and all pulses drop asynchronously, the transaction is lost, counters clear.

Optional Feature:
- MEM_ARB_RR_EN defined: round-robin arbitration.
  - On a tie, grant the requester that did not win the last grant (last-grant flop updated on every grant).
  - Starve counter and STARVE_LIMIT are unused.
- Undefined: data-priority-with-starvation-limit as above; last-grant flop absent.

Test Plan:
- Single fetch: if_req, if_addr=0x100; mem_ack 3 cycles after mem_req with rdata=0xDEADBEEF -> if_gnt at N, mem_addr=0x100 from N+1 to mem_ack, if_valid one cycle with if_rdata=0xDEADBEEF; d_* outputs stay 0.
- Store: d_req, d_we=1, d_addr=0x200, d_wdata=0x12345678, d_wmask=4'b0011 -> mem_we=1 with the same fields, d_valid pulse, d_rdata=0.
- Contention, default build, STARVE_LIMIT=4: if_req and d_req held continuously -> grant order D,D,D,D,IF,D,D,D,D,IF.
- Contention with MEM_ARB_RR_EN: both requests held from reset -> grant order IF,D,IF,D,...
- Reset mid-op: assert rst_n low while in BUSY_D before mem_ack -> mem_req=0 immediately, no d_valid; after release, a fresh if_req is granted normally.
- Zero-wait back-to-back: mem_ack tied high one cycle after mem_req, fetch requests held -> if_valid at N+2, next if_gnt in the same cycle as that if_valid.
